// File: rtl/vred_and_or_xor_seq.sv
// Sequential AND/OR/XOR vector reduction: a seed plus a stream of element beats fold into one result.
// Optional macro VRED_AND_OR_XOR_SEQ_MASK_EN adds in_mask; inactive beats leave the accumulator unchanged.
module vred_and_or_xor_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_start,
    input  logic [OPSEL_WIDTH-1:0] in_opSel,
    input  logic [DATA_WIDTH-1:0]  in_seed,
    input  logic                   in_empty,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
`ifdef VRED_AND_OR_XOR_SEQ_MASK_EN
    input  logic                   in_mask,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [OPSEL_WIDTH-1:0] OP_ZERO = OPSEL_WIDTH'(0);
    localparam logic [OPSEL_WIDTH-1:0] OP_AND  = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OP_OR   = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OP_XOR  = OPSEL_WIDTH'(3);

    logic [1:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [OPSEL_WIDTH-1:0] op_q, op_d;
    logic                   beat_active;

    function automatic logic [DATA_WIDTH-1:0] apply_op(
        input logic [OPSEL_WIDTH-1:0] op,
        input logic [DATA_WIDTH-1:0]  a,
        input logic [DATA_WIDTH-1:0]  b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef VRED_AND_OR_XOR_SEQ_MASK_EN
    assign beat_active = in_mask;
`else
    assign beat_active = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    op_d = in_opSel;
                    if (in_empty) begin
                        // No beats will follow, so the result is the seed (or zero for op 00).
                        acc_d   = (in_opSel == OP_ZERO) ? '0 : in_seed;
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = in_seed;
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    if (beat_active) begin
                        acc_d = apply_op(op_q, acc_q, in_data);
                    end
                    if (in_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= OP_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_vred_and_or_xor_seq.sv
// Self-checking bench for vred_and_or_xor_seq: directed scenarios plus randomized reductions
// checked against a behavioural fold model; mask coverage when VRED_AND_OR_XOR_SEQ_MASK_EN is defined.
module tb_vred_and_or_xor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic [1:0]  in_opSel;
    logic [31:0] in_seed;
    logic        in_empty;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] beat_data [0:15];
    bit          beat_mask [0:15];

    always #5 clk = ~clk;

    vred_and_or_xor_seq #(.DATA_WIDTH(32), .OPSEL_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_opSel  (in_opSel),
        .in_seed   (in_seed),
        .in_empty  (in_empty),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef VRED_AND_OR_XOR_SEQ_MASK_EN
        .in_mask   (in_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Advance one clock and settle just after the edge, where both driving and sampling happen.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: fold the active beats into the seed; op 00 zeroes on any active beat.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] seed, input int n);
        logic [31:0] a;
        if (n == 0) return (op == 2'b00) ? 32'h0 : seed;
        a = seed;
        for (int i = 0; i < n; i++) begin
            if (beat_mask[i]) begin
                case (op)
                    2'b01:   a = a & beat_data[i];
                    2'b10:   a = a | beat_data[i];
                    2'b11:   a = a ^ beat_data[i];
                    default: a = 32'h0;
                endcase
            end
        end
        return a;
    endfunction

    task automatic run_reduction(input string name, input logic [1:0] op, input logic [31:0] seed,
                                 input int n, input int hold, input bit gaps, input bit poke_start);
        logic [31:0] exp;
        int ngap;
        exp = model(op, seed, n);
        in_start = 1'b1;
        in_opSel = op;
        in_seed  = seed;
        in_empty = (n == 0);
        step();
        in_start = 1'b0;
        in_empty = 1'b0;
        for (int i = 0; i < n; i++) begin
            ngap = gaps ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < ngap; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = $urandom_range(0, 1);
                step();
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL %s_gap: in_ready=%b out_valid=%b out_data=%h, required 1 0 00000000",
                             name, in_ready, out_valid, out_data);
                end
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_ready_beat%0d: in_ready=%b, required 1", name, i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = beat_data[i];
            in_last  = (i == n - 1);
            in_mask  = beat_mask[i];
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_mask  = 1'b1;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_result: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                     name, out_valid, out_data, in_ready, exp);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (poke_start) begin
                in_start = 1'b1;
                in_empty = 1'b1;
                in_seed  = 32'hDEAD_BEEF;
                in_opSel = 2'b10;
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                failures++;
                $display("[TB] FAIL %s_hold%0d: out_valid=%b out_data=%h, required 1 %h",
                         name, h, out_valid, out_data, exp);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_start  = 1'b0;
        in_empty  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_accept: out_valid=%b out_data=%h in_ready=%b, required 0 00000000 0",
                     name, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: out_valid=%b in_ready=%b out_data=%h, required 0 0 00000000",
                     out_valid, in_ready, out_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_xor();
        beat_data[0] = 32'h0F0F_0F0F; beat_mask[0] = 1'b1;
        beat_data[1] = 32'hFFFF_0000; beat_mask[1] = 1'b1;
        run_reduction("xor_directed", 2'b11, 32'h0000_00FF, 2, 1, 1'b0, 1'b0);
        checks++;
        if (model(2'b11, 32'h0000_00FF, 2) !== 32'hF0F0_0FF0) begin
            failures++;
            $display("[TB] FAIL xor_model: model=%h, required f0f00ff0", model(2'b11, 32'h0000_00FF, 2));
        end
    endtask

    task automatic test_empty();
        run_reduction("and_empty", 2'b01, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        run_reduction("zero_empty", 2'b00, 32'h1234_5678, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_hold_or();
        beat_data[0] = 32'h1;  beat_mask[0] = 1'b1;
        beat_data[1] = 32'h10; beat_mask[1] = 1'b1;
        run_reduction("or_hold", 2'b10, 32'h0, 2, 5, 1'b0, 1'b1);
    endtask

    task automatic test_reset_abort();
        in_start = 1'b1; in_opSel = 2'b01; in_seed = 32'hFFFF_FFFF; in_empty = 1'b0;
        step();
        in_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h00FF_00FF; in_last = 1'b0;
            step();
        end
        rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
                failures++;
                $display("[TB] FAIL abort_idle%0d: out_valid=%b in_ready=%b out_data=%h, required 0 0 00000000",
                         c, out_valid, in_ready, out_data);
            end
            in_valid = 1'b1; in_last = 1'b1;
            step();
            in_valid = 1'b0; in_last = 1'b0;
        end
        beat_data[0] = 32'h0F0F_0F0F; beat_mask[0] = 1'b1;
        run_reduction("and_after_abort", 2'b01, 32'hFFFF_FFFF, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                beat_data[i] = $urandom;
`ifdef VRED_AND_OR_XOR_SEQ_MASK_EN
                beat_mask[i] = ($urandom_range(0, 3) != 0);
`else
                beat_mask[i] = 1'b1;
`endif
            end
            run_reduction($sformatf("random%0d", t), 2'($urandom_range(0, 3)), $urandom, n,
                          $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef VRED_AND_OR_XOR_SEQ_MASK_EN
    task automatic test_mask();
        beat_data[0] = 32'h0000_FFFF; beat_mask[0] = 1'b1;
        beat_data[1] = 32'h0;         beat_mask[1] = 1'b0;
        run_reduction("mask_and", 2'b01, 32'hFFFF_FFFF, 2, 1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1; in_start = 1'b0; in_opSel = 2'b00; in_seed = 32'h0; in_empty = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; in_mask = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = 32'h0;
            beat_mask[i] = 1'b1;
        end
        test_reset();
        test_xor();
        test_empty();
        test_hold_or();
        test_reset_abort();
`ifdef VRED_AND_OR_XOR_SEQ_MASK_EN
        test_mask();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vred_and_or_xor_seq.md
VRED_AND_OR_XOR_SEQ -- requirements
Module: vred_and_or_xor_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element and result width in bits.
REQ-002 Parameter OPSEL_WIDTH, default 2: operation select width; 01=and, 10=or, 11=xor, 00=zero result.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_start  input  1  begin one reduction; sampled only in IDLE.
REQ-006 in_opSel  input  OPSEL_WIDTH  operation; latched when in_start is accepted.
REQ-007 in_seed  input  DATA_WIDTH  scalar seed (vs1[0]); latched as accumulator initial value when in_start is accepted.
REQ-008 in_empty  input  1  qualifies in_start: vector length is zero, no element beats follow.
REQ-009 in_valid  input  1  element beat valid.
REQ-010 in_ready  output  1  element beat accepted when in_valid and in_ready are both high.
REQ-011 in_data  input  DATA_WIDTH  element value.
REQ-012 in_last  input  1  marks final element beat.
REQ-013 out_valid  output  1  result valid; held until accepted.
REQ-014 out_ready  input  1  result accepted when out_valid and out_ready are both high.
REQ-015 out_data  output  DATA_WIDTH  reduction result.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-017 IDLE: in_start with in_empty=0 SHALL latch op and seed and go to ACCUM; in_start with in_empty=1 SHALL latch op, set acc=(op==00 ? 0 : seed), and go to DONE.
REQ-018 in_ready SHALL be high only in ACCUM; in_start outside IDLE SHALL be ignored.
REQ-019 Each accepted beat SHALL update acc <= acc OP in_data (and/or/xor per latched op); op 00 SHALL set acc to 0.
REQ-020 An accepted beat with in_last=1 SHALL move the FSM to DONE in the same edge; out_valid SHALL be high the next cycle (latency 1 from last beat).
REQ-021 Beats with in_valid low SHALL leave acc and state unchanged; gaps of any length are legal.
REQ-022 DONE: out_valid=1, out_data=acc held stable until out_ready=1, then return to IDLE; a new in_start in the same cycle as result acceptance SHALL be ignored.
REQ-023 out_data SHALL be 0 whenever out_valid is low.
REQ-024 Single-beat vector (first beat carries in_last) SHALL produce seed OP element.

Reset
REQ-025 rst high at any clock edge SHALL force IDLE, acc=0, out_valid=0, in_ready=0, out_data=0, op=00, aborting any reduction in progress without emitting a result.
REQ-026 rst SHALL take precedence over in_start, beat acceptance and out_ready in the same cycle.

Configuration
REQ-027 Macro VRED_AND_OR_XOR_SEQ_MASK_EN SHALL, when defined, add port in_mask (input, 1): an accepted beat with in_mask=0 SHALL leave acc unchanged (identity element), but its in_last SHALL still terminate the reduction.
REQ-028 Without VRED_AND_OR_XOR_SEQ_MASK_EN, in_mask SHALL not exist and every accepted beat SHALL be active.

Verification
REQ-029 xor: seed 0x0000_00FF, beats 0x0F0F_0F0F, 0xFFFF_0000(last) -> out_data 0xF0F0_0FF0 one cycle after last beat.
REQ-030 and with empty: in_start, in_empty=1, seed 0x1234_5678 -> out_valid next cycle, out_data 0x1234_5678; op 00 same stimulus -> 0x0000_0000.
REQ-031 or, out_ready held low 5 cycles: seed 0, beats 0x1, 0x10(last) -> out_data 0x11 stable all 5 cycles; in_start during DONE ignored.
REQ-032 rst asserted after 2 of 4 beats -> out_valid never rises; next reduction (and, seed 0xFFFF_FFFF, beat 0x0F0F_0F0F last) -> 0x0F0F_0F0F.
REQ-033 MASK_EN, and: seed 0xFFFF_FFFF, beats 0x0000_FFFF(mask=1), 0x0(mask=0, last) -> 0x0000_FFFF.
